// File: rtl/sram_ctrl.sv
// sram_ctrl - bus-cycle controller for an external asynchronous SRAM.
//
// Arbitrates NCH request channels onto one SRAM and runs each transfer as
// IDLE -> SETUP (1 cycle) -> ACCESS (WS+1 cycles) -> HOLD (1 cycle) -> IDLE.
// Every SRAM pin and ack comes from a flop, so nothing from req reaches the
// pins combinationally. Asserting rst_n aborts a transfer at once: the
// strobes rise asynchronously and no ack is issued.
//
// Build option:
//   SRAM_CTRL_RR_EN  defined   -> round-robin arbitration (search from pointer+1)
//                    undefined -> fixed priority (lowest index wins)
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   req[NCH]        per-channel request level, held until that channel's ack
//   we[NCH]         per-channel direction (1 = write, 0 = read)
//   addr[NCH*AW]    per-channel address, channel i at [i*AW +: AW]
//   wdata[NCH*DW]   per-channel write data, channel i at [i*DW +: DW]
//   ack[NCH]        one-cycle completion pulse to the granted channel
//   rdata[DW]       read data, valid with ack of a read, held until next read
//   busy            high whenever the FSM is not in IDLE
//   sram_a/sram_d   SRAM address and bidirectional data
//   sram_ce_n/oe_n/we_n  SRAM strobes, active low
module sram_ctrl #(
  parameter int AW  = 20,
  parameter int DW  = 8,
  parameter int NCH = 2,
  parameter int WS  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    req,
  input  logic [NCH-1:0]    we,
  input  logic [NCH*AW-1:0] addr,
  input  logic [NCH*DW-1:0] wdata,
  output logic [NCH-1:0]    ack,
  output logic [DW-1:0]     rdata,
  output logic              busy,
  output logic [AW-1:0]     sram_a,
  inout  wire  [DW-1:0]     sram_d,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_e;

  state_e          state_q;
  logic [NCH-1:0]  gnt_d;
  logic [NCH-1:0]  gnt_q;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [3:0]      cnt_q;
  logic            ce_n_q, oe_n_q, we_n_q;
  logic            drive_q;
  logic [NCH-1:0]  ack_q;
  logic [DW-1:0]   rdata_q;
  logic            start;

  // A new transfer can only begin from IDLE; requests arriving mid-transfer wait.
  assign start = (state_q == IDLE) && (|req);

`ifdef SRAM_CTRL_RR_EN
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [CW-1:0] ptr_q;
  int            gidx_d;

  // Walk offsets from the farthest (the pointer itself) to the nearest
  // (pointer+1) so the nearest set request is the one left standing.
  always_comb begin
    gnt_d  = '0;
    gidx_d = 0;
    for (int k = NCH; k >= 1; k--) begin
      if (req[(int'(ptr_q) + k) % NCH]) begin
        gnt_d = '0;
        gnt_d[(int'(ptr_q) + k) % NCH] = 1'b1;
        gidx_d = (int'(ptr_q) + k) % NCH;
      end
    end
  end

  // Reset value NCH-1 makes channel 0 the first winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= CW'(NCH - 1);
    end else if (start) begin
      ptr_q <= CW'(gidx_d);
    end
  end
`else
  // Descending walk: the lowest-index set request is written last and wins.
  always_comb begin
    gnt_d = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (req[k]) begin
        gnt_d = '0;
        gnt_d[k] = 1'b1;
      end
    end
  end
`endif

  // One-hot mux of the winning channel's transfer parameters.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NCH; i++) begin
      if (gnt_d[i]) begin
        sel_we    = we[i];
        sel_addr  = addr[i*AW +: AW];
        sel_wdata = wdata[i*DW +: DW];
      end
    end
  end

  // Write data only matters while drive_q is set, so it needs no reset.
  always_ff @(posedge clk) begin
    if (start) begin
      wdata_q <= sel_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      drive_q <= 1'b0;
      ack_q   <= '0;
      rdata_q <= '0;
    end else begin
      ack_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            gnt_q   <= gnt_d;
            we_q    <= sel_we;
            addr_q  <= sel_addr;
            ce_n_q  <= 1'b0;
            oe_n_q  <= sel_we;
            drive_q <= sel_we;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          we_n_q  <= ~we_q;
          cnt_q   <= 4'(WS);
          state_q <= ACCESS;
        end
        ACCESS: begin
          if (cnt_q == '0) begin
            // Strobes rise together; data (for a write) stays driven through HOLD.
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            ack_q   <= gnt_q;
            if (!we_q) begin
              rdata_q <= sram_d;
            end
            state_q <= HOLD;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        HOLD: begin
          drive_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sram_d    = drive_q ? wdata_q : {DW{1'bz}};
  assign sram_a    = addr_q;
  assign sram_ce_n = ce_n_q;
  assign sram_oe_n = oe_n_q;
  assign sram_we_n = we_n_q;
  assign ack       = ack_q;
  assign rdata     = rdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: a WS=1/NCH=2 instance and a WS=0/NCH=1 instance,
// each with a small behavioural SRAM. Expected acks are queued when a
// transfer is issued and popped by a monitor whenever ack is seen.
// The data buses carry pull-ups, so an undriven bus reads as all ones.
`timescale 1ns/1ps
module tb_sram_ctrl;
  localparam int WS1 = 1;
  localparam logic [7:0] ZB = 8'hFF;

  typedef struct {
    int         ch;
    bit         rd;
    logic [7:0] d;
    int         cyc;
  } sb_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  // ---------------- WS=1, NCH=2 instance ----------------
  logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [19:0] addr0 = '0, addr1 = '0;
  logic [7:0]  wd0 = '0, wd1 = '0;
  logic [1:0]  req, we;
  logic [39:0] addr;
  logic [15:0] wdata;
  logic [1:0]  ack;
  logic [7:0]  rdata;
  logic        busy;
  logic [19:0] sram_a;
  wire  [7:0]  sram_d;
  logic        ce_n, oe_n, we_n;
  logic [7:0]  mem1 [0:1023];

  assign req   = {req1, req0};
  assign we    = {we1, we0};
  assign addr  = {addr1, addr0};
  assign wdata = {wd1, wd0};

  sram_ctrl #(.AW(20), .DW(8), .NCH(2), .WS(WS1)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .busy(busy), .sram_a(sram_a), .sram_d(sram_d),
    .sram_ce_n(ce_n), .sram_oe_n(oe_n), .sram_we_n(we_n)
  );

  assign sram_d = (!ce_n && !oe_n && we_n) ? mem1[sram_a[9:0]] : 8'hzz;
  always @(negedge clk) if (!ce_n && !we_n) mem1[sram_a[9:0]] <= sram_d;

  // ---------------- WS=0, NCH=1 instance ----------------
  logic [0:0]  req_b = '0, we_b = '0;
  logic [19:0] addr_b = '0;
  logic [7:0]  wd_b = '0;
  logic [0:0]  ack_b;
  logic [7:0]  rdata_b;
  logic        busy_b;
  logic [19:0] sram_a_b;
  wire  [7:0]  sram_d_b;
  logic        ce_n_b, oe_n_b, we_n_b;
  logic [7:0]  mem0 [0:15];

  sram_ctrl #(.AW(20), .DW(8), .NCH(1), .WS(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req_b), .we(we_b), .addr(addr_b), .wdata(wd_b),
    .ack(ack_b), .rdata(rdata_b), .busy(busy_b), .sram_a(sram_a_b), .sram_d(sram_d_b),
    .sram_ce_n(ce_n_b), .sram_oe_n(oe_n_b), .sram_we_n(we_n_b)
  );

  assign sram_d_b = (!ce_n_b && !oe_n_b && we_n_b) ? mem0[sram_a_b[3:0]] : 8'hzz;
  always @(negedge clk) if (!ce_n_b && !we_n_b) mem0[sram_a_b[3:0]] <= sram_d_b;

  for (genvar g = 0; g < 8; g++) begin : g_pull
    pullup (sram_d[g]);
    pullup (sram_d_b[g]);
  end

  sb_t q1[$];
  sb_t q0[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (ack[i]) begin
          if (q1.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_ack: ack[%0d] high, no transfer queued (cycle %0d)", i, cyc);
          end else begin
            sb_t e;
            e = q1.pop_front();
            chk("ack_channel", i, e.ch);
            chk("ack_cycle", cyc, e.cyc);
            if (e.rd) chk("rdata", {24'h0, rdata}, {24'h0, e.d});
          end
        end
      end
      if (ack_b[0]) begin
        if (q0.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_ack_b: ack high, no transfer queued (cycle %0d)", cyc);
        end else begin
          sb_t e;
          e = q0.pop_front();
          chk("b_ack_cycle", cyc, e.cyc);
          if (e.rd) chk("b_rdata", {24'h0, rdata_b}, {24'h0, e.d});
        end
      end
    end
  end

  // ---------------- pin trace checker (cycles 1..5 after issue) ----------------
  bit          tr_on = 0;
  bit          tr_wr = 0;
  int          tr_base = 0;
  logic [19:0] tr_a = '0;
  logic [7:0]  tr_d = '0;

  always @(negedge clk) begin
    int k;
    k = cyc - tr_base;
    if (tr_on && k >= 1 && k <= 5) begin
      chk("ce_n", ce_n, (k <= 3) ? 0 : 1);
      chk("we_n", we_n, (tr_wr && (k == 2 || k == 3)) ? 0 : 1);
      chk("oe_n", oe_n, (!tr_wr && k <= 3) ? 0 : 1);
      if (k <= 4) chk("sram_a", sram_a, tr_a);
      if (tr_wr) chk("sram_d", {24'h0, sram_d}, {24'h0, (k <= 4) ? tr_d : ZB});
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_ack(input int ch);
    bit got;
    got = 0;
    for (int t = 0; t < 40 && !got; t++) begin
      @(negedge clk);
      if (ack[ch]) got = 1;
    end
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL ack_timeout: ch%0d got no ack within 40 cycles", ch);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge ending the ack cycle.
  task automatic xfer(input int ch, input logic w, input logic [19:0] a,
                      input logic [7:0] d, input logic [7:0] erd);
    sb_t e;
    e.ch = ch; e.rd = !w; e.d = erd; e.cyc = cyc + WS1 + 3;
    q1.push_back(e);
    if (ch == 0) begin we0 = w; addr0 = a; wd0 = d; req0 = 1; end
    else         begin we1 = w; addr1 = a; wd1 = d; req1 = 1; end
    wait_ack(ch);
    @(posedge clk); #1;
    if (ch == 0) req0 = 0; else req1 = 0;
  endtask

  task automatic xfer_b(input logic w, input logic [19:0] a, input logic [7:0] d,
                        input logic [7:0] erd);
    sb_t e;
    bit  got;
    e.ch = 0; e.rd = !w; e.d = erd; e.cyc = cyc + 3;
    q0.push_back(e);
    we_b = w; addr_b = a; wd_b = d; req_b = 1;
    @(negedge clk);
    chk("b_turnaround_strobes", {ce_n_b, oe_n_b, we_n_b}, 3'b111);
    got = ack_b[0];
    for (int t = 0; t < 40 && !got; t++) begin
      @(negedge clk);
      if (ack_b[0]) got = 1;
    end
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL b_ack_timeout: no ack within 40 cycles");
    end
    @(posedge clk); #1;
    req_b = 0;
  endtask

  task automatic gap();
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    int ord[4];
    int c0;
    int rem0, rem1;

    rst_n = 0;
    #12;
    chk("rst_strobes", {ce_n, oe_n, we_n}, 3'b111);
    chk("rst_sram_a", sram_a, 0);
    chk("rst_sram_d", {24'h0, sram_d}, {24'h0, ZB});
    chk("rst_ack", ack, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_busy", {busy, busy_b}, 2'b00);
    @(posedge clk); #1;
    rst_n = 1;
    gap();

    // Reset in the middle of a write: everything drops asynchronously.
    we0 = 1; addr0 = 20'h00077; wd0 = 8'h5A; req0 = 1;
    @(posedge clk); @(posedge clk);
    #2;
    chk("abort_pre_we_n", we_n, 0);
    rst_n = 0;
    #1;
    chk("abort_strobes", {ce_n, oe_n, we_n}, 3'b111);
    chk("abort_sram_d", {24'h0, sram_d}, {24'h0, ZB});
    chk("abort_ack", ack, 0);
    chk("abort_busy", busy, 0);
    req0 = 0;
    @(posedge clk); #1;
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("busy_after_reset", busy, 0);
    end
    @(posedge clk); #1;

    // ch0 writes 0xA5 to 0x12345 with pin trace.
    tr_base = cyc; tr_wr = 1; tr_a = 20'h12345; tr_d = 8'hA5; tr_on = 1;
    xfer(0, 1, 20'h12345, 8'hA5, 8'h00);
    gap();

    // ch1 reads it back.
    tr_base = cyc; tr_wr = 0; tr_a = 20'h12345; tr_on = 1;
    xfer(1, 0, 20'h12345, 8'h00, 8'hA5);
    gap();
    tr_on = 0;

    // Writes leave rdata alone; last grant here is ch1.
    xfer(0, 1, 20'h00010, 8'h11, 8'h00);
    chk("rdata_kept_after_write", rdata, 8'hA5);
    xfer(1, 1, 20'h00020, 8'h22, 8'h00);
    chk("rdata_kept_after_write2", rdata, 8'hA5);
    gap();

    // Contention: both channels request two reads each.
`ifdef SRAM_CTRL_RR_EN
    ord[0] = 0; ord[1] = 1; ord[2] = 0; ord[3] = 1;
`else
    ord[0] = 0; ord[1] = 0; ord[2] = 1; ord[3] = 1;
`endif
    c0 = cyc;
    for (int j = 0; j < 4; j++) begin
      sb_t e;
      e.ch = ord[j]; e.rd = 1; e.d = (ord[j] == 0) ? 8'h11 : 8'h22;
      e.cyc = c0 + WS1 + 3 + j * (WS1 + 4);
      q1.push_back(e);
    end
    we0 = 0; addr0 = 20'h00010; we1 = 0; addr1 = 20'h00020;
    req0 = 1; req1 = 1;
    rem0 = 2; rem1 = 2;
    for (int t = 0; t < 60 && (rem0 > 0 || rem1 > 0); t++) begin
      @(negedge clk);
      if (ack[0]) rem0--;
      if (ack[1]) rem1--;
      @(posedge clk); #1;
      if (rem0 == 0) req0 = 0;
      if (rem1 == 0) req1 = 0;
    end
    chk("contention_done", {rem0[7:0], rem1[7:0]}, 0);
    req0 = 0; req1 = 0;
    gap();

    // Granted channel changes addr/wdata during ACCESS.
    tr_base = cyc; tr_wr = 1; tr_a = 20'h00040; tr_d = 8'h3C; tr_on = 1;
    begin
      sb_t e;
      e.ch = 0; e.rd = 0; e.d = 8'h00; e.cyc = cyc + WS1 + 3;
      q1.push_back(e);
    end
    we0 = 1; addr0 = 20'h00040; wd0 = 8'h3C; req0 = 1;
    @(posedge clk); @(posedge clk); #1;
    addr0 = 20'h00050; wd0 = 8'hFF;
    wait_ack(0);
    @(posedge clk); #1;
    req0 = 0;
    chk("new_addr_not_written", (mem1[10'h050] === 8'hFF), 0);
    xfer(0, 1, 20'h00050, 8'hFF, 8'h00);
    tr_on = 0;
    chk("latched_write_mem", mem1[10'h040], 8'h3C);
    chk("next_write_mem", mem1[10'h050], 8'hFF);
    xfer(1, 0, 20'h00040, 8'h00, 8'h3C);
    gap();

    // WS=0, NCH=1 instance: write then back-to-back reads.
    xfer_b(1, 20'h00003, 8'h33, 8'h00);
    xfer_b(0, 20'h00003, 8'h00, 8'h33);
    xfer_b(0, 20'h00003, 8'h00, 8'h33);
    gap();

    for (int t = 0; t < 20 && (q1.size() != 0 || q0.size() != 0); t++) @(posedge clk);
    chk("queues_drained", q1.size() + q0.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
